oled_init_sequencer: RTL

- Drives the 5-bit command index into the OLED startup command ROM and serializes the returned command bytes to the SSD1331 over 4-wire SPI.
- Also performs the panel power-up sequence: PMODEN, RES# pulse, VCCEN before display-on, and the settle wait.
- Sits between the top-level/display controller (start/done handshake) and the PmodOLEDrgb pins.
- Once done, the pixel-streaming stage takes over the SPI bus.

---
 rtl/oled_init_sequencer.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/oled_init_sequencer.sv
// Purpose : SSD1331 power-up and init sequencer; walks the startup command ROM and shifts each command out on 4-wire SPI (mode 3).
// Latency : power-up takes POWER_DELAY + 2*RESET_CYCLES cycles to first CS fall; each byte is 16*CLK_DIV cycles; done after ON_DELAY.
// Backpressure: none; start_in is a one-cycle pulse, accepted only in IDLE or DONE and ignored while busy_out is high.
//
// Ports:
//   clk_in, rst_n_in                : clock, async active-low reset
//   start_in / busy_out / done_out  : controller handshake
//   command_out                     : ROM index; comm_length_in / comm_data_in return combinationally
//   sclk_out, mosi_out, cs_n_out, dc_out : SPI to the panel (dc is always command)
//   res_n_out, vccen_out, pmoden_out     : panel power and reset controls
module oled_init_sequencer #(
    parameter int CLK_DIV      = 5,
    parameter int NUM_COMMANDS = 25,
    parameter int POWER_DELAY  = 2_000_000,
    parameter int RESET_CYCLES = 300,
    parameter int ON_DELAY     = 10_000_000
) (
    input  logic         clk_in,
    input  logic         rst_n_in,
    input  logic         start_in,
    output logic [4:0]   command_out,
    input  logic [3:0]   comm_length_in,
    input  logic [119:0] comm_data_in,
    output logic         sclk_out,
    output logic         mosi_out,
    output logic         cs_n_out,
    output logic         dc_out,
    output logic         res_n_out,
    output logic         vccen_out,
    output logic         pmoden_out,
    output logic         busy_out,
    output logic         done_out
);

    localparam int MAX_A = (POWER_DELAY > ON_DELAY) ? POWER_DELAY : ON_DELAY;
    localparam int MAX_B = (RESET_CYCLES > CLK_DIV) ? RESET_CYCLES : CLK_DIV;
    localparam int MAX_D = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAX_D + 1);

    localparam logic [4:0]    LAST_IDX  = 5'(NUM_COMMANDS - 1);
    localparam logic [CW-1:0] PWR_END   = CW'(POWER_DELAY - 1);
    localparam logic [CW-1:0] RLOW_END  = CW'(RESET_CYCLES - 1);
    // The LOAD cycle is counted as the last cycle of the settle waits that
    // lead into a command, so CS falls exactly N cycles after the event.
    localparam logic [CW-1:0] RWAIT_END = CW'(RESET_CYCLES - 2);
    localparam logic [CW-1:0] VCC_END   = CW'(POWER_DELAY - 2);
    localparam logic [CW-1:0] ON_END    = CW'(ON_DELAY - 1);
    localparam logic [CW-1:0] HALF_END  = CW'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        IDLE, PWR_WAIT, RST_LOW, RST_WAIT, LOAD, SHIFT, GAP, VCC_WAIT, ON_WAIT, DONE
    } state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [119:0]   shreg;
    logic [3:0]     byte_cnt;
    logic [2:0]     bit_cnt;

    // Where to go once the current command is finished (sent or skipped).
    logic [4:0] next_idx;
    logic       at_last;
    logic       next_last;
    state_t     adv_state;

    assign next_idx  = command_out + 5'd1;
    assign at_last   = (command_out == LAST_IDX);
    assign next_last = (next_idx == LAST_IDX);
    assign adv_state = at_last ? ON_WAIT : (next_last ? VCC_WAIT : LOAD);

    // Pixel data is the next stage's job; this block only ever sends commands.
    assign dc_out = 1'b0;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state       <= IDLE;
            cnt         <= '0;
            shreg       <= '0;
            byte_cnt    <= '0;
            bit_cnt     <= '0;
            command_out <= '0;
            sclk_out    <= 1'b1;
            mosi_out    <= 1'b0;
            cs_n_out    <= 1'b1;
            res_n_out   <= 1'b1;
            vccen_out   <= 1'b0;
            pmoden_out  <= 1'b0;
            busy_out    <= 1'b0;
            done_out    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_in) begin
                        state      <= PWR_WAIT;
                        cnt        <= '0;
                        pmoden_out <= 1'b1;
                        vccen_out  <= 1'b0;
                        busy_out   <= 1'b1;
                        done_out   <= 1'b0;
                    end
                end
                PWR_WAIT: begin
                    if (cnt == PWR_END) begin
                        state     <= RST_LOW;
                        cnt       <= '0;
                        res_n_out <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RST_LOW: begin
                    if (cnt == RLOW_END) begin
                        state     <= RST_WAIT;
                        cnt       <= '0;
                        res_n_out <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RST_WAIT: begin
                    if (cnt == RWAIT_END) begin
                        state       <= LOAD;
                        cnt         <= '0;
                        command_out <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                LOAD: begin
                    shreg    <= comm_data_in;
                    byte_cnt <= comm_length_in;
                    bit_cnt  <= '0;
                    cnt      <= '0;
                    if (comm_length_in == 4'd0) begin
                        // Empty entry: move on without framing anything.
                        state       <= adv_state;
                        command_out <= at_last ? command_out : next_idx;
                        if (adv_state == VCC_WAIT) vccen_out <= 1'b1;
                    end else begin
                        state    <= SHIFT;
                        cs_n_out <= 1'b0;
                        sclk_out <= 1'b0;
                        mosi_out <= comm_data_in[119];
                    end
                end
                SHIFT: begin
                    if (cnt != HALF_END) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        cnt <= '0;
                        if (!sclk_out) begin
                            sclk_out <= 1'b1;
                        end else begin
                            // End of a bit: falling boundary is the only place MOSI moves.
                            if (bit_cnt == 3'd7) byte_cnt <= byte_cnt - 4'd1;
                            if (bit_cnt == 3'd7 && byte_cnt == 4'd1) begin
                                state    <= GAP;
                                cs_n_out <= 1'b1;
                                mosi_out <= 1'b0;
                            end else begin
                                sclk_out <= 1'b0;
                                bit_cnt  <= bit_cnt + 3'd1;
                                mosi_out <= shreg[118];
                                shreg    <= {shreg[118:0], 1'b0};
                            end
                        end
                    end
                end
                GAP: begin
                    if (cnt == HALF_END) begin
                        cnt         <= '0;
                        state       <= adv_state;
                        command_out <= at_last ? command_out : next_idx;
                        if (adv_state == VCC_WAIT) vccen_out <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                VCC_WAIT: begin
                    if (cnt == VCC_END) begin
                        state <= LOAD;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ON_WAIT: begin
                    if (cnt == ON_END) begin
                        state    <= DONE;
                        cnt      <= '0;
                        busy_out <= 1'b0;
                        done_out <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
